// File: rtl/img_pkg.sv
// Shared types and constants for the histogram / equalization LUT builder.
package img_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_COUNT,
    ST_DRAIN,
    ST_ACCUM
  } state_t;

  // Bit positions inside the sticky error vector.
  localparam int unsigned ERR_PIX_CNT    = 0;  // pixel count at frame end != TOTAL
  localparam int unsigned ERR_LATE_FSYNC = 1;  // fsync while the LUT is being built
  localparam int unsigned ERR_ABORT      = 2;  // fsync in the middle of counting
  localparam int unsigned ERR_HSYNC      = 3;  // hsync outside of vsync

  // Active pixels per frame.
  function automatic logic [63:0] calc_total(input int unsigned hori,
                                             input int unsigned vert);
    return 64'(hori) * 64'(vert);
  endfunction

  // Fixed-point CDF scale: ((2^wd - 1) << 24) / total.
  function automatic logic [63:0] calc_k(input int unsigned wd_pix,
                                         input logic [63:0] total);
    return (((64'd1 << wd_pix) - 64'd1) << 24) / total;
  endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port bin RAM: one write port, one read port, 1-cycle read latency.
module hist_bin_ram #(
  parameter int unsigned WD_ADR = 8,
  parameter int unsigned WD_DAT = 20
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WD_ADR-1:0] waddr_i,
  input  logic [WD_DAT-1:0] wdata_i,
  input  logic [WD_ADR-1:0] raddr_i,
  output logic [WD_DAT-1:0] rdata_o
);

  logic [WD_DAT-1:0] mem_q [2**WD_ADR];
  logic [WD_DAT-1:0] rdata_q;

  // Registered read returns the contents before a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/histogram_lut_build.sv
// Counts the gray-level histogram of each frame and, in vertical blanking,
// turns its cumulative distribution into the equalization LUT on BRAM port A.
module histogram_lut_build
  import img_pkg::*;
#(
  parameter int unsigned MD_SIM_ABLE = 0,
  parameter int unsigned NB_IMG_HORI = 960,
  parameter int unsigned NB_IMG_VERT = 640,
  parameter int unsigned WD_IMG_DATA = 8,
  parameter int unsigned WD_BRAM_ADR = 8,
  parameter int unsigned WD_BRAM_DAT = 32,
  parameter int unsigned WD_HIST_CNT = 20,
  parameter int unsigned WD_ERR_INFO = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   s_img_gray_c_fsync,
  input  logic                   s_img_gray_c_vsync,
  input  logic                   s_img_gray_c_hsync,
  input  logic [WD_IMG_DATA-1:0] s_img_gray_y_mdat0,
  output logic                   m_bram_equal_ena,
  output logic                   m_bram_equal_wea,
  output logic [WD_BRAM_ADR-1:0] m_bram_equal_addra,
  output logic [WD_BRAM_DAT-1:0] m_bram_equal_dina,
  output logic                   m_lut_done,
  output logic [WD_ERR_INFO-1:0] m_err_histogram_info0
);

  localparam int unsigned NBIN    = 1 << WD_IMG_DATA;
  localparam int unsigned WD_ACC  = WD_IMG_DATA + 2;
  localparam int unsigned WD_PROD = WD_HIST_CNT + 25;
  localparam logic [63:0] TOTAL   = calc_total(NB_IMG_HORI, NB_IMG_VERT);

  localparam logic [WD_HIST_CNT-1:0] TOTAL_C   = WD_HIST_CNT'(TOTAL);
  localparam logic [WD_PROD-1:0]     K_C       = WD_PROD'(calc_k(WD_IMG_DATA, TOTAL));
  localparam logic [WD_PROD-1:0]     RND_C     = WD_PROD'(64'd1 << 23);
  localparam logic [WD_PROD-1:0]     LUT_MAX_C = WD_PROD'((64'd1 << WD_IMG_DATA) - 64'd1);
  localparam logic [WD_ACC-1:0]      ACC_RD_C  = WD_ACC'(NBIN);
  localparam logic [WD_ACC-1:0]      ACC_END_C = WD_ACC'(NBIN + 2);

  state_t                  state_q;
  logic                    vsync_q;
  logic                    drain_q;
  logic [WD_HIST_CNT-1:0]  pix_cnt_q;
  logic [WD_IMG_DATA-1:0]  clr_cnt_q;
  logic [WD_ACC-1:0]       acc_cnt_q;

  // Count-phase read-modify-write pipeline and forwarding register.
  logic                    rmw_v1_q;
  logic [WD_IMG_DATA-1:0]  rmw_a1_q;
  logic                    fwd_v_q;
  logic [WD_IMG_DATA-1:0]  fwd_a_q;
  logic [WD_HIST_CNT-1:0]  fwd_d_q;

  // Accumulate-phase pipeline.
  logic                    acc_v1_q;
  logic [WD_IMG_DATA-1:0]  acc_a1_q;
  logic                    acc_v2_q;
  logic [WD_IMG_DATA-1:0]  acc_a2_q;
  logic [WD_HIST_CNT-1:0]  cdf_q;

  // Registered outputs.
  logic                    ena_q;
  logic                    wea_q;
  logic [WD_BRAM_ADR-1:0]  addra_q;
  logic [WD_BRAM_DAT-1:0]  dina_q;
  logic                    done_q;
  logic [WD_ERR_INFO-1:0]  err_q;

  logic                    pix_vld_d;
  logic                    vfall_d;
  logic                    acc_rd_d;
  logic [WD_HIST_CNT-1:0]  rmw_inc_d;
  logic                    ram_we_d;
  logic [WD_IMG_DATA-1:0]  ram_waddr_d;
  logic [WD_HIST_CNT-1:0]  ram_wdata_d;
  logic [WD_IMG_DATA-1:0]  ram_raddr_d;
  logic [WD_HIST_CNT-1:0]  ram_rdata;
  logic [WD_PROD-1:0]      prod_d;
  logic [WD_PROD-1:0]      scaled_d;
  logic [WD_IMG_DATA-1:0]  lut_d;

  hist_bin_ram #(
    .WD_ADR(WD_IMG_DATA),
    .WD_DAT(WD_HIST_CNT)
  ) u_bin_ram (
    .clk_i  (i_sys_clk),
    .we_i   (ram_we_d),
    .waddr_i(ram_waddr_d),
    .wdata_i(ram_wdata_d),
    .raddr_i(ram_raddr_d),
    .rdata_o(ram_rdata)
  );

  // Event decode and bin RAM port arbitration; write sources never overlap by construction.
  always_comb begin
    pix_vld_d = (state_q == ST_COUNT) && s_img_gray_c_vsync && s_img_gray_c_hsync
                && !s_img_gray_c_fsync;
    vfall_d   = vsync_q && !s_img_gray_c_vsync;
    acc_rd_d  = (state_q == ST_ACCUM) && (acc_cnt_q < ACC_RD_C);
    // The read issued last cycle cannot see the write made in that same cycle.
    if (fwd_v_q && (fwd_a_q == rmw_a1_q)) rmw_inc_d = fwd_d_q + 1'b1;
    else                                  rmw_inc_d = ram_rdata + 1'b1;

    ram_raddr_d = acc_rd_d ? acc_cnt_q[WD_IMG_DATA-1:0] : s_img_gray_y_mdat0;
    ram_we_d    = 1'b0;
    ram_waddr_d = '0;
    ram_wdata_d = '0;
    if (state_q == ST_CLEAR) begin
      ram_we_d    = 1'b1;
      ram_waddr_d = clr_cnt_q;
    end else if (rmw_v1_q) begin
      ram_we_d    = 1'b1;
      ram_waddr_d = rmw_a1_q;
      ram_wdata_d = rmw_inc_d;
    end else if (acc_v1_q) begin
      ram_we_d    = 1'b1;
      ram_waddr_d = acc_a1_q;
    end
  end

  // CDF to LUT value: round(cdf * K / 2^24), saturated to the top gray level.
  always_comb begin
    prod_d   = WD_PROD'(cdf_q) * K_C;
    scaled_d = (prod_d + RND_C) >> 24;
    if (scaled_d > LUT_MAX_C) lut_d = '1;
    else                      lut_d = scaled_d[WD_IMG_DATA-1:0];
  end

  // Datapath pipelines: pixel RMW with forwarding, and bin read / CDF accumulation.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rmw_v1_q <= 1'b0;
      rmw_a1_q <= '0;
      fwd_v_q  <= 1'b0;
      fwd_a_q  <= '0;
      fwd_d_q  <= '0;
      acc_v1_q <= 1'b0;
      acc_a1_q <= '0;
      acc_v2_q <= 1'b0;
      acc_a2_q <= '0;
      cdf_q    <= '0;
    end else begin
      rmw_v1_q <= pix_vld_d;
      rmw_a1_q <= s_img_gray_y_mdat0;
      fwd_v_q  <= rmw_v1_q;
      fwd_a_q  <= rmw_a1_q;
      fwd_d_q  <= rmw_inc_d;
      acc_v1_q <= acc_rd_d;
      acc_a1_q <= acc_cnt_q[WD_IMG_DATA-1:0];
      acc_v2_q <= acc_v1_q;
      acc_a2_q <= acc_a1_q;
      if (state_q == ST_DRAIN)  cdf_q <= '0;
      else if (acc_v1_q)        cdf_q <= cdf_q + ram_rdata;
    end
  end

  // Frame-level FSM with registered port-A, done and error outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q   <= ST_CLEAR;
      vsync_q   <= 1'b0;
      drain_q   <= 1'b0;
      pix_cnt_q <= '0;
      clr_cnt_q <= '0;
      acc_cnt_q <= '0;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      vsync_q <= s_img_gray_c_vsync;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      done_q  <= 1'b0;
      if (acc_v2_q) begin
        ena_q   <= 1'b1;
        wea_q   <= 1'b1;
        addra_q <= WD_BRAM_ADR'(acc_a2_q);
        dina_q  <= WD_BRAM_DAT'(lut_d);
      end
      if (s_img_gray_c_hsync && !s_img_gray_c_vsync) err_q[ERR_HSYNC] <= 1'b1;

      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (s_img_gray_c_fsync) begin
            pix_cnt_q <= '0;
            state_q   <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (pix_vld_d && (pix_cnt_q != '1)) pix_cnt_q <= pix_cnt_q + 1'b1;
          if (vfall_d) begin
            if (pix_cnt_q != TOTAL_C)  err_q[ERR_PIX_CNT]    <= 1'b1;
            if (s_img_gray_c_fsync)    err_q[ERR_LATE_FSYNC] <= 1'b1;
            drain_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (s_img_gray_c_fsync) begin
            err_q[ERR_ABORT] <= 1'b1;
            clr_cnt_q        <= '0;
            state_q          <= ST_CLEAR;
          end
        end
        ST_DRAIN: begin
          if (s_img_gray_c_fsync) err_q[ERR_LATE_FSYNC] <= 1'b1;
          drain_q <= 1'b1;
          if (drain_q) begin
            acc_cnt_q <= '0;
            state_q   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (s_img_gray_c_fsync) err_q[ERR_LATE_FSYNC] <= 1'b1;
          acc_cnt_q <= acc_cnt_q + 1'b1;
          // Last LUT write is on the port this cycle; flag completion next cycle.
          if (acc_cnt_q == ACC_END_C) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  generate
    if (MD_SIM_ABLE != 0) begin : g_sim_chk
      // At most one source may own the bin RAM write port in any cycle.
      always_ff @(posedge i_sys_clk) begin
        if (i_sys_resetn) begin
          assert ($onehot0({state_q == ST_CLEAR, rmw_v1_q, acc_v1_q}));
        end
      end
    end
  endgenerate

  assign m_bram_equal_ena      = ena_q;
  assign m_bram_equal_wea      = wea_q;
  assign m_bram_equal_addra    = addra_q;
  assign m_bram_equal_dina     = dina_q;
  assign m_lut_done            = done_q;
  assign m_err_histogram_info0 = err_q;

endmodule

// File: tb/tb_histogram_lut_build.sv
// Scoreboard bench for histogram_lut_build on a 4x4 frame.
module tb_histogram_lut_build;

  localparam int unsigned HORI  = 4;
  localparam int unsigned VERT  = 4;
  localparam int unsigned TOTAL = HORI * VERT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsync = 1'b0;
  logic        vsync = 1'b0;
  logic        hsync = 1'b0;
  logic [7:0]  pix = '0;
  logic        ena;
  logic        wea;
  logic [7:0]  addra;
  logic [31:0] dina;
  logic        done;
  logic [3:0]  err;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_addr_q[$];
  int unsigned exp_dat_q[$];
  int unsigned frame_pix[$];
  int unsigned exp_done = 0;
  int unsigned done_cnt = 0;
  int unsigned wr_cnt = 0;
  int unsigned wr_mark;
  logic [3:0]  exp_err = '0;
  bit          mon_en = 1'b1;

  always #5 clk = ~clk;

  histogram_lut_build #(
    .MD_SIM_ABLE(1),
    .NB_IMG_HORI(HORI),
    .NB_IMG_VERT(VERT),
    .WD_IMG_DATA(8),
    .WD_BRAM_ADR(8),
    .WD_BRAM_DAT(32),
    .WD_HIST_CNT(20),
    .WD_ERR_INFO(4)
  ) dut (
    .i_sys_clk            (clk),
    .i_sys_resetn         (rst_n),
    .s_img_gray_c_fsync   (fsync),
    .s_img_gray_c_vsync   (vsync),
    .s_img_gray_c_hsync   (hsync),
    .s_img_gray_y_mdat0   (pix),
    .m_bram_equal_ena     (ena),
    .m_bram_equal_wea     (wea),
    .m_bram_equal_addra   (addra),
    .m_bram_equal_dina    (dina),
    .m_lut_done           (done),
    .m_err_histogram_info0(err)
  );

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: LUT[v] from the count of pixels <= v, scaled to the gray range.
  task automatic push_expected();
    longint unsigned k, cdf, lut;
    k = (64'd255 << 24) / 64'(TOTAL);
    for (int unsigned v = 0; v < 256; v++) begin
      cdf = 0;
      foreach (frame_pix[j]) if (frame_pix[j] <= v) cdf++;
      lut = (cdf * k + (64'd1 << 23)) >> 24;
      if (lut > 255) lut = 255;
      exp_addr_q.push_back(v);
      exp_dat_q.push_back(int'(lut));
    end
    exp_done++;
  endtask

  // One frame: fsync pulse, then frame_pix under vsync with random hsync gaps.
  // abort_at >= 0 inserts a second fsync before that pixel.
  task automatic drive_frame(input int unsigned max_gap, input int abort_at);
    cyc();
    fsync = 1'b1;
    cyc();
    fsync = 1'b0;
    vsync = 1'b1;
    cyc();
    foreach (frame_pix[j]) begin
      if (j == abort_at) begin
        fsync = 1'b1;
        cyc();
        fsync = 1'b0;
      end
      hsync = 1'b1;
      pix   = 8'(frame_pix[j]);
      cyc();
      hsync = 1'b0;
      repeat ($urandom_range(0, max_gap)) cyc();
    end
    hsync = 1'b0;
    vsync = 1'b0;
    cyc();
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (exp_addr_q.size() != 0 && n < 3000) begin
      cyc();
      n++;
    end
    repeat (5) cyc();
    check("queue_drained", exp_addr_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    check("err_flags", err, exp_err);
  endtask

  task automatic set_const(input int unsigned v, input int unsigned n);
    frame_pix.delete();
    repeat (n) frame_pix.push_back(v);
  endtask

  task automatic set_ramp();
    frame_pix.delete();
    for (int unsigned i = 0; i < TOTAL; i++) frame_pix.push_back(i);
  endtask

  task automatic set_random();
    int unsigned base, r;
    frame_pix.delete();
    base = $urandom_range(0, 255);
    for (int unsigned i = 0; i < TOTAL; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      frame_pix.push_back($urandom_range(0, 255));
      else if (r == 1) frame_pix.push_back(base);
      else             frame_pix.push_back((base + 1) & 255);
    end
  endtask

  initial begin
    fork
      begin : monitor
        bit prev_wr, prev_wr255;
        int unsigned ea, ed;
        prev_wr = 1'b0;
        prev_wr255 = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst_n || !mon_en) begin
            prev_wr = 1'b0;
            prev_wr255 = 1'b0;
          end else begin
            if (ena || wea) begin
              wr_cnt++;
              if (exp_addr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr=%0d dat=%0d with no write expected",
                         addra, dina);
              end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_dat_q.pop_front();
                tests++;
                if (!(ena && wea && addra == 8'(ea) && dina == ed)) begin
                  fails++;
                  $display("FAIL lut_write: got ena=%0b wea=%0b addr=%0d dat=%0d, expected 1 1 addr=%0d dat=%0d",
                           ena, wea, addra, dina, ea, ed);
                end
              end
              if (addra != 0) check("write_contiguous", prev_wr, 1);
            end
            if (done) begin
              done_cnt++;
              check("done_after_255", prev_wr255, 1);
            end
            prev_wr    = ena;
            prev_wr255 = ena && (addra == 8'd255);
          end
        end
      end
      begin : stimulus
        // Reset state.
        repeat (3) cyc();
        check("reset_outputs", {ena, wea, addra, dina, done, err}, 0);
        rst_n = 1'b1;
        repeat (300) cyc();

        // All pixels equal: back-to-back RMW on one bin.
        set_const(100, TOTAL);
        push_expected();
        drive_frame(0, -1);
        wait_drain();

        // Ramp directly after: relies on bins having been cleared.
        set_ramp();
        push_expected();
        drive_frame(1, -1);
        wait_drain();

        // Random frames with many repeated / adjacent values.
        repeat (5) begin
          set_random();
          push_expected();
          drive_frame(2, -1);
          wait_drain();
        end

        // Short frame: LUT still written, pixel-count error raised.
        set_const(7, TOTAL - 1);
        push_expected();
        exp_err[0] = 1'b1;
        drive_frame(1, -1);
        wait_drain();

        // fsync while the LUT is being built: that frame is skipped.
        wr_mark = wr_cnt;
        set_random();
        push_expected();
        drive_frame(1, -1);
        repeat (30) cyc();
        set_ramp();
        drive_frame(1, -1);
        exp_err[1] = 1'b1;
        wait_drain();
        repeat (300) cyc();
        check("late_fsync_writes", wr_cnt - wr_mark, 256);
        check("late_fsync_done", done_cnt, exp_done);

        // fsync mid-count: abort, no writes, next frame is correct.
        wr_mark = wr_cnt;
        set_ramp();
        drive_frame(0, 5);
        exp_err[2] = 1'b1;
        repeat (300) cyc();
        check("abort_writes", wr_cnt - wr_mark, 0);
        check("abort_err", err, exp_err);
        set_random();
        push_expected();
        drive_frame(2, -1);
        wait_drain();

        // Reset in the middle of the LUT writes.
        mon_en = 1'b0;
        set_random();
        drive_frame(1, -1);
        repeat (40) cyc();
        #3 rst_n = 1'b0;
        #2 check("reset_mid_accum", {ena, wea, addra, dina, done, err}, 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        mon_en = 1'b1;
        exp_err = '0;
        // A frame during the post-reset clear pass is ignored silently.
        wr_mark = wr_cnt;
        set_ramp();
        drive_frame(0, -1);
        repeat (300) cyc();
        check("clear_fsync_writes", wr_cnt - wr_mark, 0);
        check("clear_fsync_err", err, 0);
        set_ramp();
        push_expected();
        drive_frame(1, -1);
        wait_drain();

        // hsync without vsync.
        hsync = 1'b1;
        cyc();
        hsync = 1'b0;
        repeat (3) cyc();
        exp_err[3] = 1'b1;
        check("hsync_err", err, exp_err);
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
